// File: rtl/shift_reg_universal_pkg.sv
// Package for the universal shift register slice.
// Holds the operation-select encoding seen at the top-level mode port,
// the per-stage next-value select used between top and stage, and the
// stage behaviour applied to the reserved mode encodings (6 and 7).
package shift_pkg;

  // Operation select driven on the mode port; 3'd6/3'd7 are reserved.
  typedef enum logic [2:0] {
    HOLD = 3'd0,
    SHL  = 3'd1,
    SHR  = 3'd2,
    ROTL = 3'd3,
    ROTR = 3'd4,
    LOAD = 3'd5
  } shift_mode_t;

  // Next-value source for one stage.
  typedef enum logic [1:0] {
    SEL_HOLD  = 2'd0,
    SEL_LEFT  = 2'd1,
    SEL_RIGHT = 2'd2,
    SEL_PAR   = 2'd3
  } stage_sel_t;

  // Reserved mode encodings leave the data untouched.
  localparam stage_sel_t RESERVED_MODE_SEL = SEL_HOLD;

endpackage

// File: rtl/shift_reg_universal_stage.sv
// shift_stage: one WIDTH-bit word of the universal shift register.
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   clear             synchronous clear to zero (wins over en and sel)
//   en                when low the word holds
//   sel               next-value source: hold / left / right / parallel
//   left_in           word from the lower-index neighbour (or wrap/sin)
//   right_in          word from the higher-index neighbour (or wrap/sin)
//   par_in            parallel load word
//   data_q            registered stage contents
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  stage_sel_t       sel,
  input  logic [WIDTH-1:0] left_in,
  input  logic [WIDTH-1:0] right_in,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] data_q
);

  logic [WIDTH-1:0] data_d;

  // Next-value selection: clear beats enable, enable gates the source mux.
  always_comb begin
    data_d = data_q;
    if (clear) begin
      data_d = {WIDTH{1'b0}};
    end else if (!en) begin
      data_d = data_q;
    end else begin
      case (sel)
        SEL_HOLD:  data_d = data_q;
        SEL_LEFT:  data_d = left_in;
        SEL_RIGHT: data_d = right_in;
        SEL_PAR:   data_d = par_in;
        default:   data_d = data_q;
      endcase
    end
  end

  // Stage register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= {WIDTH{1'b0}};
    end else begin
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/shift_reg_universal.sv
// shift_reg_universal: DEPTH stages of WIDTH-bit words supporting hold,
// shift left/right, rotate left/right and parallel load, plus a
// saturating count of words shifted/loaded since the last clear.
// Ports:
//   clk, reset   rising-edge clock, async active-high reset
//   clear        synchronous clear of data and count
//   en           low: all state holds
//   mode         operation select (shift_mode_t; 6/7 behave as HOLD)
//   sin          serial input word
//   pin          parallel load, stage i = pin[i*WIDTH +: WIDTH]
//   sout_hi      stage DEPTH-1 (output end for SHL)
//   sout_lo      stage 0 (output end for SHR)
//   pout         all stages, same packing as pin
//   count        saturating occupancy count (0..DEPTH)
//   full, empty  decodes of count
module shift_reg_universal
  import shift_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   en,
  input  shift_mode_t            mode,
  input  logic [WIDTH-1:0]       sin,
  input  logic [WIDTH*DEPTH-1:0] pin,
  output logic [WIDTH-1:0]       sout_hi,
  output logic [WIDTH-1:0]       sout_lo,
  output logic [WIDTH*DEPTH-1:0] pout,
  output logic [CW-1:0]          count,
  output logic                   full,
  output logic                   empty
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  stage_sel_t       sel_s;
  logic [WIDTH-1:0] stage_s [DEPTH];
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    count_q;

  // Map the operation onto the common per-stage source select.
  always_comb begin
    sel_s = SEL_HOLD;
    case (mode)
      HOLD:    sel_s = SEL_HOLD;
      SHL:     sel_s = SEL_LEFT;
      ROTL:    sel_s = SEL_LEFT;
      SHR:     sel_s = SEL_RIGHT;
      ROTR:    sel_s = SEL_RIGHT;
      LOAD:    sel_s = SEL_PAR;
      default: sel_s = RESERVED_MODE_SEL;
    endcase
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] left_s;
    logic [WIDTH-1:0] right_s;

    // End stages take sin when shifting, the opposite end when rotating.
    // With DEPTH=1 the wrap source is the stage itself, so rotates hold.
    if (i == 0) begin : g_left_end
      assign left_s = (mode == ROTL) ? stage_s[DEPTH-1] : sin;
    end else begin : g_left_mid
      assign left_s = stage_s[i-1];
    end

    if (i == DEPTH - 1) begin : g_right_end
      assign right_s = (mode == ROTR) ? stage_s[0] : sin;
    end else begin : g_right_mid
      assign right_s = stage_s[i+1];
    end

    shift_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .en       (en),
      .sel      (sel_s),
      .left_in  (left_s),
      .right_in (right_s),
      .par_in   (pin[i*WIDTH +: WIDTH]),
      .data_q   (stage_s[i])
    );

    assign pout[i*WIDTH +: WIDTH] = stage_s[i];
  end

  assign sout_hi = stage_s[DEPTH-1];
  assign sout_lo = stage_s[0];

  // Occupancy: shifts count up to DEPTH, load fills, rotates/hold keep.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = {CW{1'b0}};
    end else if (!en) begin
      count_d = count_q;
    end else begin
      case (mode)
        SHL, SHR: begin
          if (count_q != DEPTH_C) begin
            count_d = count_q + CW'(1);
          end else begin
            count_d = count_q;
          end
        end
        LOAD:    count_d = DEPTH_C;
        default: count_d = count_q;
      endcase
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == {CW{1'b0}});

endmodule

// File: tb/tb_shift_reg_universal.sv
module tb_shift_reg_universal;
  import shift_pkg::*;

  logic clk;
  logic reset;

  // a: WIDTH=1, DEPTH=3 (defaults)
  logic        a_clear, a_en;
  shift_mode_t a_mode;
  logic [0:0]  a_sin, a_hi, a_lo;
  logic [2:0]  a_pin, a_pout;
  logic [1:0]  a_count;
  logic        a_full, a_empty;

  // b: WIDTH=8, DEPTH=4
  logic        b_clear, b_en;
  shift_mode_t b_mode;
  logic [7:0]  b_sin, b_hi, b_lo;
  logic [31:0] b_pin, b_pout;
  logic [2:0]  b_count;
  logic        b_full, b_empty;

  // c: WIDTH=4, DEPTH=1
  logic        c_clear, c_en;
  shift_mode_t c_mode;
  logic [3:0]  c_sin, c_hi, c_lo, c_pin, c_pout;
  logic [0:0]  c_count;
  logic        c_full, c_empty;

  int compared;
  int mismatched;

  shift_reg_universal u_a (
    .clk(clk), .reset(reset), .clear(a_clear), .en(a_en), .mode(a_mode),
    .sin(a_sin), .pin(a_pin), .sout_hi(a_hi), .sout_lo(a_lo), .pout(a_pout),
    .count(a_count), .full(a_full), .empty(a_empty)
  );

  shift_reg_universal #(.WIDTH(8), .DEPTH(4)) u_b (
    .clk(clk), .reset(reset), .clear(b_clear), .en(b_en), .mode(b_mode),
    .sin(b_sin), .pin(b_pin), .sout_hi(b_hi), .sout_lo(b_lo), .pout(b_pout),
    .count(b_count), .full(b_full), .empty(b_empty)
  );

  shift_reg_universal #(.WIDTH(4), .DEPTH(1)) u_c (
    .clk(clk), .reset(reset), .clear(c_clear), .en(c_en), .mode(c_mode),
    .sin(c_sin), .pin(c_pin), .sout_hi(c_hi), .sout_lo(c_lo), .pout(c_pout),
    .count(c_count), .full(c_full), .empty(c_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset   = 1'b1;
    a_clear = 1'b0; a_en = 1'b1; a_mode = SHL;  a_sin = 1'b1; a_pin = 3'd0;
    b_clear = 1'b0; b_en = 1'b1; b_mode = HOLD; b_sin = 8'h00; b_pin = 32'h0;
    c_clear = 1'b0; c_en = 1'b1; c_mode = HOLD; c_sin = 4'h0; c_pin = 4'h0;

    // Reset defaults while edges run with SHL/sin=1
    step(); step();
    check("rst_a_pout",  a_pout,  3'b000);
    check("rst_a_hi",    a_hi,    1'b0);
    check("rst_a_lo",    a_lo,    1'b0);
    check("rst_a_count", a_count, 2'd0);
    check("rst_a_empty", a_empty, 1'b1);
    check("rst_a_full",  a_full,  1'b0);
    check("rst_b_pout",  b_pout,  32'h0);
    check("rst_b_empty", b_empty, 1'b1);
    check("rst_c_empty", c_empty, 1'b1);

    // Serial delay: sin=1,0,1 then 0
    reset = 1'b0;
    a_sin = 1'b1; step();
    check("shl_e1_count", a_count, 2'd1);
    check("shl_e1_empty", a_empty, 1'b0);
    a_sin = 1'b0; step();
    check("shl_e2_pout",  a_pout,  3'b010);
    check("shl_e2_count", a_count, 2'd2);
    a_sin = 1'b1; step();
    check("shl_e3_hi",    a_hi,    1'b1);
    check("shl_e3_pout",  a_pout,  3'b101);
    check("shl_e3_full",  a_full,  1'b1);
    a_sin = 1'b0; step();
    check("shl_e4_hi",    a_hi,    1'b0);
    check("shl_e4_count", a_count, 2'd3);
    step();
    check("shl_e5_hi",    a_hi,    1'b1);
    check("shl_e5_full",  a_full,  1'b1);
    check("shl_e5_count", a_count, 2'd3);
    a_mode = HOLD;

    // Load and rotate
    b_mode = LOAD; b_pin = 32'h44332211; step();
    check("load_pout",   b_pout,  32'h44332211);
    check("load_full",   b_full,  1'b1);
    check("load_count",  b_count, 3'd4);
    b_mode = ROTL; step();
    check("rotl_pout",   b_pout,  32'h33221144);
    check("rotl_count",  b_count, 3'd4);
    b_mode = ROTR; step();
    check("rotr1_pout",  b_pout,  32'h44332211);
    step();
    check("rotr2_pout",  b_pout,  32'h11443322);
    check("rotr2_count", b_count, 3'd4);

    // Priority: en=0 blocks everything, reserved modes hold
    b_en = 1'b0; b_mode = LOAD; b_pin = 32'hDEADBEEF; step();
    check("en0_load_pout", b_pout, 32'h11443322);
    b_mode = SHR; b_sin = 8'hFF; step();
    check("en0_shr_pout",  b_pout, 32'h11443322);
    check("en0_shr_count", b_count, 3'd4);
    b_en = 1'b1; b_mode = shift_mode_t'(3'd6); step();
    check("mode6_pout",    b_pout, 32'h11443322);
    b_mode = shift_mode_t'(3'd7); step();
    check("mode7_pout",    b_pout, 32'h11443322);
    check("mode7_count",   b_count, 3'd4);
    b_clear = 1'b1; b_mode = LOAD; step();
    check("clr_load_pout",  b_pout,  32'h0);
    check("clr_load_count", b_count, 3'd0);
    check("clr_load_empty", b_empty, 1'b1);
    check("clr_load_full",  b_full,  1'b0);
    b_clear = 1'b0;

    // SHR direction and saturation
    b_mode = SHR; b_sin = 8'hA5;
    step(); step(); step();
    check("shr_e3_lo",    b_lo,    8'h00);
    check("shr_e3_count", b_count, 3'd3);
    step();
    check("shr_e4_lo",    b_lo,    8'hA5);
    check("shr_e4_count", b_count, 3'd4);
    check("shr_e4_full",  b_full,  1'b1);
    b_sin = 8'h5A; step();
    check("shr_sat_pout",  b_pout,  32'h5AA5A5A5);
    check("shr_sat_count", b_count, 3'd4);
    b_mode = SHL; b_sin = 8'h01; step();
    check("shl_b_pout", b_pout, 32'hA5A5A501);
    check("shl_b_hi",   b_hi,   8'hA5);
    b_mode = HOLD;

    // Async reset mid-shift
    a_clear = 1'b1; step();
    check("a_clr_count", a_count, 2'd0);
    check("a_clr_pout",  a_pout,  3'b000);
    a_clear = 1'b0; a_mode = SHL; a_sin = 1'b1;
    step(); step();
    check("mid_count2", a_count, 2'd2);
    check("mid_pout2",  a_pout,  3'b011);
    #2 reset = 1'b1;
    #1;
    check("async_pout",  a_pout,  3'b000);
    check("async_count", a_count, 2'd0);
    check("async_empty", a_empty, 1'b1);
    check("async_b",     b_pout,  32'h0);
    #1 reset = 1'b0;
    step();
    check("post_rst_count", a_count, 2'd1);
    check("post_rst_pout",  a_pout,  3'b001);
    a_mode = HOLD;

    // DEPTH=1 corner
    c_mode = LOAD; c_pin = 4'h9; step();
    check("d1_load_pout", c_pout, 4'h9);
    check("d1_load_full", c_full, 1'b1);
    c_mode = ROTL; step();
    check("d1_rotl_pout", c_pout, 4'h9);
    c_mode = ROTR; step();
    check("d1_rotr_pout", c_pout, 4'h9);
    c_mode = SHL; c_sin = 4'h5; step();
    check("d1_shl_hi",    c_hi,   4'h5);
    check("d1_shl_lo",    c_lo,   4'h5);
    check("d1_shl_full",  c_full, 1'b1);
    c_mode = SHR; c_sin = 4'h3; step();
    check("d1_shr_lo",    c_lo,   4'h3);
    check("d1_shr_count", c_count, 1'b1);
    check("d1_shr_empty", c_empty, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
